// File: rtl/square_pkg.sv
// Shared definitions for the squarer and the square-root datapath.
// Holds the default operand format and the squarer state encoding.
package square_pkg;

  localparam int IN_W_DEF   = 26;
  localparam int FRAC_W_DEF = 13;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_RUN,
    SQ_DONE
  } sq_state_t;

endpackage

// File: rtl/square_step.sv
// One shift-add step of the squarer: conditionally adds the multiplicand.
// Kept separate so a radix-4 step can replace it without touching the FSM.
module square_step #(
  parameter int W = 52
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] mcand_i,
  input  logic         bit_i,
  output logic [W-1:0] acc_o
);

  assign acc_o = bit_i ? (acc_i + mcand_i) : acc_i;

endmodule

// File: rtl/fixed_point_square.sv
// Sequential LSB-first shift-add squarer, exact 2*IN_W-bit result in IN_W+2 cycles.
// Optional remainder output A_ref - X*X is enabled by defining SQUARE_REMAINDER_EN.
module fixed_point_square
  import square_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  start,
  input  logic [IN_W-1:0]       X,
`ifdef SQUARE_REMAINDER_EN
  input  logic [2*IN_W-1:0]     A_ref,
  output logic signed [2*IN_W:0] R,
  output logic                  R_neg,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2*IN_W-1:0]     Y
);

  localparam int OW = 2 * IN_W;
  localparam int CW = $clog2(IN_W);
  // FRAC_W only documents the binary point; the arithmetic is format-agnostic.
  localparam int unused_frac_w = FRAC_W;

  sq_state_t         state_q;
  logic [IN_W-1:0]   x_sh_q;
  logic [OW-1:0]     mcand_q;
  logic [OW-1:0]     acc_q;
  logic [OW-1:0]     acc_d;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [OW-1:0]     y_q;

  square_step #(.W(OW)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (x_sh_q[0]),
    .acc_o   (acc_d)
  );

`ifdef SQUARE_REMAINDER_EN
  logic [OW-1:0]        aref_q;
  logic signed [OW:0]   r_q;
  logic signed [OW:0]   rem_d;
  logic                 r_neg_q;

  assign rem_d = $signed({1'b0, aref_q}) - $signed({1'b0, acc_q});

  always_ff @(posedge clk) begin
    if (!rst_) begin
      aref_q  <= '0;
      r_q     <= '0;
      r_neg_q <= 1'b0;
    end else if (state_q == SQ_IDLE && !busy_q && start) begin
      aref_q <= A_ref;
    end else if (state_q == SQ_DONE) begin
      r_q     <= rem_d;
      r_neg_q <= rem_d[OW];
    end
  end

  assign R     = r_q;
  assign R_neg = r_neg_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= SQ_IDLE;
      x_sh_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      case (state_q)
        SQ_IDLE: begin
          done_q <= 1'b0;
          // busy_q still set here means this is the done cycle: start is ignored.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            busy_q  <= 1'b1;
            x_sh_q  <= X;
            mcand_q <= {{IN_W{1'b0}}, X};
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SQ_RUN;
          end
        end
        SQ_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          x_sh_q  <= x_sh_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(IN_W - 1)) begin
            state_q <= SQ_DONE;
          end
        end
        SQ_DONE: begin
          y_q     <= acc_q;
          done_q  <= 1'b1;
          state_q <= SQ_IDLE;
        end
        default: begin
          state_q <= SQ_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;

endmodule

// File: tb/tb_fixed_point_square.sv
// Directed and random checks of fixed_point_square against plain X*X arithmetic.
// Remainder checks are compiled in when SQUARE_REMAINDER_EN is defined.
module tb_fixed_point_square;

  localparam int IN_W = 26;
  localparam int OW   = 2 * IN_W;
  localparam int P    = IN_W + 3;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              start = 1'b0;
  logic [IN_W-1:0]   X = '0;
  logic              busy;
  logic              done;
  logic [OW-1:0]     Y;
`ifdef SQUARE_REMAINDER_EN
  logic [OW-1:0]     A_ref = '0;
  logic signed [OW:0] R;
  logic              R_neg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int          last_lat;
  int          last_busy_n;
  logic [OW-1:0] last_y;
  logic        last_busy_after;
  logic        last_done_after;

  fixed_point_square #(.IN_W(IN_W), .FRAC_W(13)) dut (
    .clk   (clk),
    .rst_  (rst_),
    .start (start),
    .X     (X),
`ifdef SQUARE_REMAINDER_EN
    .A_ref (A_ref),
    .R     (R),
    .R_neg (R_neg),
`endif
    .busy  (busy),
    .done  (done),
    .Y     (Y)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sq(input logic [IN_W-1:0] x);
    longint unsigned xv;
    xv = 64'(x);
    return xv * xv;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
  task automatic run_op(input logic [IN_W-1:0] x, input logic [OW-1:0] aref);
    X = x;
`ifdef SQUARE_REMAINDER_EN
    A_ref = aref;
`else
    if (aref != '0) X = x;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = IN_W'($urandom);
    last_lat    = -1;
    last_busy_n = busy ? 1 : 0;
    for (int k = 1; k <= IN_W + 10; k++) begin
      @(posedge clk); #1;
      if (busy) last_busy_n++;
      if (done) begin
        last_lat = k;
        break;
      end
    end
    last_y = Y;
    @(posedge clk); #1;
    last_busy_after = busy;
    last_done_after = done;
  endtask

  initial begin
    logic [63:0] exp_y;
    logic [63:0] exp_q[$];
    int pulses;
    logic [OW-1:0] y_seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_Y", 64'(Y), 64'd0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // X=0: full latency, no early exit
    run_op('0, '0);
    check("zero_Y", 64'(last_y), 64'd0);
    check("zero_latency", 64'(last_lat), 64'(IN_W + 1));
    check("zero_busy_cycles", 64'(last_busy_n), 64'(IN_W + 2));
    check("zero_busy_after", 64'(last_busy_after), 64'd0);
    check("zero_done_after", 64'(last_done_after), 64'd0);

    run_op(26'd3, '0);
    check("three_Y", 64'(last_y), 64'd9);
    run_op(26'h2000, '0);
    check("one_q13_Y", 64'(last_y), 64'h400_0000);
    run_op(26'h3FF_FFFF, '0);
    check("max_Y", 64'(last_y), 64'hF_FFFF_F800_0001);
    check("max_latency", 64'(last_lat), 64'(IN_W + 1));

    // Re-pulse mid-RUN must be ignored
    X = 26'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    X = 26'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    y_seen = '0;
    for (int k = 0; k < 3 * P; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        y_seen = Y;
      end
    end
    check("repulse_Y", 64'(y_seen), 64'd49);
    check("repulse_pulses", 64'(pulses), 64'd1);
    check("repulse_idle", 64'(busy), 64'd0);

    // Reset mid-RUN at count 10 discards the operation
    X = 26'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_ = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_Y", 64'(Y), 64'd0);
    run_op(26'd4, '0);
    check("after_reset_Y", 64'(last_y), 64'd16);
    check("after_reset_latency", 64'(last_lat), 64'(IN_W + 1));

`ifdef SQUARE_REMAINDER_EN
    run_op(26'd3, 52'd10);
    check("rem_3_10_R", 64'(longint'(R)), 64'd1);
    check("rem_3_10_neg", 64'(R_neg), 64'd0);
    run_op(26'd4, 52'd10);
    check("rem_4_10_R", 64'(longint'(R)), 64'(-64'sd6));
    check("rem_4_10_neg", 64'(R_neg), 64'd1);
    run_op(26'd3, 52'd9);
    check("rem_3_9_R", 64'(longint'(R)), 64'd0);
    check("rem_3_9_neg", 64'(R_neg), 64'd0);
`endif

    // Random operands
    for (int i = 0; i < 1500; i++) begin
      logic [IN_W-1:0] xr;
      xr = IN_W'($urandom);
      if (i % 100 == 1) xr = '1;
      if (i % 100 == 2) xr = '0;
      run_op(xr, '0);
      check("random_Y", 64'(last_y), sq(xr));
    end

    // start held high: one accept every IN_W+3 cycles, X changing each cycle
    start = 1'b1;
    for (int n = 0; n < 4 * P; n++) begin
      X = IN_W'($urandom);
      if (n % P == 0) exp_q.push_back(sq(X));
      @(posedge clk); #1;
      if (n % P == IN_W + 1) begin
        check("stream_done", 64'(done), 64'd1);
        exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        check("stream_Y", 64'(Y), exp_y);
      end else begin
        check("stream_no_done", 64'(done), 64'd0);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
